// File: rtl/pool_scan_controller.sv
// Raster-scan front end for a 2x2 pooling engine with a 2-entry result FIFO.
// Optional statistics counters are built only when POOL_CTRL_STATS_EN is defined.
module pool_scan_controller #(
   parameter int WIDTH  = 128,
   parameter int HEIGHT = 128
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_in_valid,
   input  logic [7:0]  i_in_data,
   output logic        o_in_ready,
   output logic [7:0]  o_relu_in,
   output logic [10:0] o_x,
   output logic [9:0]  o_y,
   input  logic [7:0]  i_pool_out,
   input  logic        i_pool_valid,
   output logic        o_out_valid,
   output logic [7:0]  o_out_data,
   input  logic        i_out_ready,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_frame_cnt,
   output logic [31:0] o_stall_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   localparam logic [10:0] XMAX = 11'(WIDTH - 1);
   localparam logic [9:0]  YMAX = 10'(HEIGHT - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [10:0] r_sx;
   logic [9:0]  r_sy;
   logic        r_inflight;
   logic [1:0]  r_count;
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [7:0]  r_mem [2];

   logic w_accept;
   logic w_last_px;
   logic w_odd_px;
   logic w_capture;
   logic w_pop;

   // A pending result reserves a FIFO slot, so a capture can never find the FIFO full.
   assign o_in_ready  = (r_state == S_RUN) &&
                        (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2);
   assign w_accept    = i_in_valid && o_in_ready;
   assign w_last_px   = (r_sx == XMAX) && (r_sy == YMAX);
   assign w_odd_px    = r_sx[0] & r_sy[0];
   assign w_capture   = r_inflight && i_pool_valid;
   assign o_out_valid = (r_count != 2'd0);
   assign w_pop       = o_out_valid && i_out_ready;
   assign o_out_data  = r_mem[r_rd_ptr];
   assign o_busy      = (r_state == S_RUN) || (r_state == S_FLUSH);
   assign o_done      = (r_state == S_DONE);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_state_nxt = S_RUN;
         S_RUN:   if (w_accept && w_last_px) w_state_nxt = S_FLUSH;
         S_FLUSH: if ((r_count == 2'd0) && !r_inflight) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_sx      <= '0;
         r_sy      <= '0;
         o_relu_in <= '0;
         o_x       <= '0;
         o_y       <= '0;
      end else if ((r_state == S_IDLE) && i_start) begin
         r_sx <= '0;
         r_sy <= '0;
      end else if (w_accept) begin
         o_relu_in <= i_in_data;
         o_x       <= r_sx;
         o_y       <= r_sy;
         if (r_sx == XMAX) begin
            r_sx <= '0;
            r_sy <= r_sy + 10'd1;
         end else begin
            r_sx <= r_sx + 11'd1;
         end
      end
   end

   // A new odd/odd pixel wins over a capture landing on the same edge.
   always_ff @(posedge i_clk) begin
      if (!i_reset)                  r_inflight <= 1'b0;
      else if (w_accept && w_odd_px) r_inflight <= 1'b1;
      else if (w_capture)            r_inflight <= 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_count  <= 2'd0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_mem[0] <= 8'd0;
         r_mem[1] <= 8'd0;
      end else begin
         if (w_capture) begin
            r_mem[r_wr_ptr] <= i_pool_out;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         case ({w_capture, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef POOL_CTRL_STATS_EN
   logic [15:0] r_frame_cnt;
   logic [31:0] r_stall_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_frame_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (r_state == S_DONE) r_frame_cnt <= r_frame_cnt + 16'd1;
         if ((r_state == S_RUN) && i_in_valid && !o_in_ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign o_frame_cnt = r_frame_cnt;
   assign o_stall_cnt = r_stall_cnt;
`else
   assign o_frame_cnt = '0;
   assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pool_scan_controller.sv
// Bench for pool_scan_controller on a 4x4 frame with a 2x2 max-pool engine model.
module tb_pool_scan_controller;
   localparam int W    = 4;
   localparam int H    = 4;
   localparam int NPIX = W * H;
   localparam int NOUT = NPIX / 4;
`ifdef POOL_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, start, in_valid, in_ready, out_valid, out_ready, busy, done;
   logic [7:0]  in_data, relu_in, out_data, pool_out;
   logic [10:0] x;
   logic [9:0]  y;
   logic        pool_valid;
   logic [15:0] frame_cnt;
   logic [31:0] stall_cnt;
   logic        spur = 1'b0;
   logic        spur_mode = 1'b0;

   always #5 clk = ~clk;

   pool_scan_controller #(.WIDTH(W), .HEIGHT(H)) dut (
      .i_clk(clk), .i_reset(reset), .i_start(start),
      .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
      .o_relu_in(relu_in), .o_x(x), .o_y(y),
      .i_pool_out(pool_out), .i_pool_valid(pool_valid),
      .o_out_valid(out_valid), .o_out_data(out_data), .i_out_ready(out_ready),
      .o_busy(busy), .o_done(done),
      .o_frame_cnt(frame_cnt), .o_stall_cnt(stall_cnt)
   );

   function automatic logic [7:0] max2(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? a : b;
   endfunction

   // Pooling engine: stores each delivered pixel, answers one cycle after an odd/odd pixel.
   logic       eng_acc_d = 1'b0;
   logic       eng_pv = 1'b0;
   logic [7:0] eng_po = 8'd0;
   logic [7:0] eng_buf [H][W];
   always @(posedge clk) begin
      eng_acc_d <= in_valid && in_ready;
      eng_pv    <= 1'b0;
      if (eng_acc_d) begin
         eng_buf[y[1:0]][x[1:0]] <= relu_in;
         if (x[0] && y[0]) begin
            eng_po <= max2(max2(eng_buf[y[1:0] - 2'd1][x[1:0] - 2'd1], eng_buf[y[1:0] - 2'd1][x[1:0]]),
                           max2(eng_buf[y[1:0]][x[1:0] - 2'd1], relu_in));
            eng_pv <= 1'b1;
         end
      end
   end
   assign pool_valid = eng_pv | spur;
   assign pool_out   = spur ? 8'hAA : eng_po;

   int n_pass = 0;
   int n_total = 0;
   int frames_model = 0;
   int stall_model = 0;
   logic [7:0] pix  [NPIX];
   logic [7:0] expv [NOUT];
   logic [7:0] got  [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic logic [7:0] pool_ref(input int k);
      int base = 2 * (k / (W / 2)) * W + 2 * (k % (W / 2));
      return max2(max2(pix[base], pix[base + 1]), max2(pix[base + W], pix[base + W + 1]));
   endfunction

   task automatic fill_pix(input int mode);
      for (int i = 0; i < NPIX; i++) begin
         case (mode)
            0:       pix[i] = 8'(i + 1);
            1:       pix[i] = 8'(NPIX - i);
            2:       pix[i] = 8'((i * 37) % 256);
            default: pix[i] = 8'($urandom);
         endcase
      end
   endtask

   task automatic check_reset_state();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_relu_in", relu_in, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
   endtask

   task automatic check_stats();
      chk("frame_cnt", frame_cnt, STATS ? frames_model : 0);
      chk("stall_cnt", stall_cnt, STATS ? stall_model : 0);
   endtask

   // The model's occupancy is odd/odd pixels accepted minus results popped.
   task automatic run_frame(input bit gaps, input int rel, input bit rnd, output int blk_at);
      int sent = 0, oo = 0, pops = 0, dones = 0, acc_cyc = -1, ov_cyc = -1;
      bit exp_rdy, off;
      blk_at = -1;
      got.delete();
      @(negedge clk);
      chk("busy_idle", busy, 0);
      start = 1'b1; in_valid = 1'b0; out_ready = (rel == 0); spur = spur_mode;
      for (int cyc = 1; cyc < 600 && dones == 0; cyc++) begin
         @(negedge clk);
         start = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
         spur = spur_mode && (sent < W);
         exp_rdy = (sent < NPIX) && (oo - pops < 2);
         chk("in_ready", in_ready, exp_rdy);
         if (sent > 0) begin
            chk("relu_in_hold", relu_in, pix[sent - 1]);
            chk("x_hold", x, (sent - 1) % W);
            chk("y_hold", y, (sent - 1) / W);
         end
         if (!in_ready && sent < NPIX && blk_at < 0) blk_at = sent;
         if (ov_cyc < 0 && out_valid) ov_cyc = cyc;
         off = (sent < NPIX) && (rnd ? ($urandom_range(0, 1) == 1) : (!gaps || cyc % 2 == 1));
         in_valid = off;
         in_data = off ? pix[sent] : 8'($urandom);
         out_ready = rnd ? ($urandom_range(0, 3) != 0) : (rel == 0 || cyc >= rel);
         if (off && !exp_rdy) stall_model++;
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            pops++;
         end
         if (off && in_ready) begin
            if ((sent % W) % 2 == 1 && (sent / W) % 2 == 1) begin
               oo++;
               if (acc_cyc < 0) acc_cyc = cyc;
            end
            sent++;
         end
         if (done) begin
            dones++;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("done_one_cycle", done, 0);
            chk("busy_after_done", busy, 0);
            @(negedge clk);
            chk("start_in_done_ignored", busy, 0);
         end
      end
      start = 1'b0; in_valid = 1'b0; spur = 1'b0;
      chk("done_pulses", dones, 1);
      chk("first_latency", ov_cyc - acc_cyc, 3);
      chk("out_count", got.size(), NOUT);
      for (int k = 0; k < got.size() && k < NOUT; k++) chk("out_data", got[k], expv[k]);
      if (dones == 1) frames_model++;
      check_stats();
   endtask

   typedef struct packed {
      int              mode;
      bit              gaps;
      int              rel;
      int              blk;
      logic [3:0][7:0] e;
   } vec_t;

   vec_t vecs [4];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int blk, acc;
      vecs[0] = '{0, 1'b0, 0,  -1, {8'd16, 8'd14, 8'd8, 8'd6}};
      vecs[1] = '{0, 1'b1, 0,  -1, {8'd16, 8'd14, 8'd8, 8'd6}};
      vecs[2] = '{1, 1'b0, 25,  8, {8'd6, 8'd8, 8'd14, 8'd16}};
      vecs[3] = '{2, 1'b1, 13, -1, {8'd151, 8'd225, 8'd222, 8'd185}};

      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state();
      reset = 1'b1;

      for (int i = 0; i < 4; i++) begin
         fill_pix(vecs[i].mode);
         for (int k = 0; k < NOUT; k++) expv[k] = vecs[i].e[k];
         run_frame(vecs[i].gaps, vecs[i].rel, 1'b0, blk);
         if (vecs[i].blk >= 0) chk("ready_drop_at_pixel", blk, vecs[i].blk);
      end

      // Spurious engine valid while idle and across the first row.
      spur = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("spur_idle_no_push", out_valid, 0);
      end
      spur = 1'b0;
      spur_mode = 1'b1;
      fill_pix(0);
      for (int k = 0; k < NOUT; k++) expv[k] = pool_ref(k);
      run_frame(1'b0, 0, 1'b0, blk);
      spur_mode = 1'b0;

      // Reset after 9 accepted pixels abandons the frame.
      fill_pix(0);
      @(negedge clk); start = 1'b1; out_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      acc = 0;
      for (int c = 0; c < 100 && acc < 9; c++) begin
         in_valid = 1'b1;
         in_data = pix[acc];
         if (in_ready) acc++;
         @(negedge clk);
      end
      chk("pixels_before_reset", acc, 9);
      in_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check_reset_state();
      @(negedge clk);
      chk("no_done_in_reset", done, 0);
      reset = 1'b1;
      frames_model = 0;
      stall_model = 0;
      for (int k = 0; k < NOUT; k++) expv[k] = pool_ref(k);
      run_frame(1'b0, 0, 1'b0, blk);

      for (int r = 0; r < 3; r++) begin
         fill_pix(3);
         for (int k = 0; k < NOUT; k++) expv[k] = pool_ref(k);
         run_frame(1'b0, 0, 1'b1, blk);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/pool_scan_controller.md
POOL_SCAN_CONTROLLER -- requirements
Module: pool_scan_controller

Interface
REQ-001 Parameter: WIDTH, 128, frame width in pixels; even, 2..2048.
REQ-002 Parameter: HEIGHT, 128, frame height in rows; even, 2..1024.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  reset is synchronous and active-low.
REQ-005 start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
REQ-006 in_valid / in_data / in_ready  in / in / out  1 / 8 / 1  ReLU pixel stream, raster order.
REQ-007 relu_in / x / y  out  8 / 11 / 10  drive to pooling engine: pixel and its coordinates.
REQ-008 pool_out / pool_valid  in  8 / 1  result and valid from pooling engine.
REQ-009 out_valid / out_data / out_ready  out / out / in  1 / 8 / 1  pooled output stream.
REQ-010 busy / done  out  1 / 1  frame in progress; one-cycle end-of-frame pulse.
REQ-011 frame_cnt / stall_cnt  out  16 / 32  statistics (see Configuration).

Function
REQ-012 FSM states SHALL be IDLE, RUN, FLUSH, DONE; busy = 1 in RUN and FLUSH.
REQ-013 IDLE->RUN on start; RUN->FLUSH when pixel (WIDTH-1, HEIGHT-1) is accepted; FLUSH->DONE when FIFO empty and nothing in flight; DONE->IDLE unconditionally after 1 cycle.
REQ-014 A pixel is accepted when in_valid && in_ready; in_ready = (state==RUN) && (fifo_count + inflight < 2).
REQ-015 On acceptance, the block SHALL register relu_in <= in_data and x/y <= current scan position, then advance x; x wraps WIDTH-1 -> 0 with y+1.
REQ-016 When no pixel is accepted, relu_in, x and y SHALL hold their previous values.
REQ-017 inflight SHALL set the cycle after an accepted pixel with x and y both odd, and clear when the result is captured.
REQ-018 A result SHALL be captured into the FIFO only when inflight && pool_valid; pool_valid at any other time SHALL be ignored.
REQ-019 The output FIFO SHALL hold 2 entries; out_valid = (count != 0); an entry pops on out_valid && out_ready.
REQ-020 A simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-021 Latency from acceptance of odd/odd pixel to out_valid SHALL be 3 cycles when the FIFO is empty.
REQ-022 A frame SHALL emit exactly (WIDTH/2)*(HEIGHT/2) outputs.
REQ-023 start outside IDLE SHALL be ignored; start in DONE SHALL NOT be queued.
REQ-024 The scan position SHALL return to (0,0) on entry to RUN.

Reset
REQ-025 With reset low at a clock edge: state=IDLE, fifo count=0, inflight=0, in_ready=0, out_valid=0, done=0, busy=0, relu_in=0, x=0, y=0, out_data=0, frame_cnt=0, stall_cnt=0.
REQ-026 Reset mid-frame SHALL abandon the frame, discard FIFO contents and any in-flight result, and SHALL NOT pulse done.

Configuration
REQ-027 Macro POOL_CTRL_STATS_EN: when defined, frame_cnt increments (wrapping) on each DONE and stall_cnt increments (saturating at all-ones) on each RUN cycle with in_valid && !in_ready.
REQ-028 When POOL_CTRL_STATS_EN is undefined, frame_cnt and stall_cnt SHALL be constant 0, the ports SHALL remain present, and no counter logic SHALL be generated.

Verification
REQ-029 WIDTH=4, HEIGHT=4, out_ready=1, 16 back-to-back pixels 1..16 -> outputs 6, 8, 14, 16 in order, one done pulse, busy low the cycle after done.
REQ-030 Same stimulus, out_ready=0 -> in_ready drops after the second odd/odd result is pending; releasing out_ready completes all 4 outputs with none lost or duplicated.
REQ-031 in_valid toggled every other cycle -> x/y/relu_in hold during gaps, outputs identical to REQ-029.
REQ-032 Reset low after 9 pixels -> next cycle out_valid=0, busy=0, no done pulse; a new start then yields a correct full frame.
REQ-033 Spurious pool_valid=1 held high in IDLE and during even pixels -> no FIFO push.
REQ-034 With POOL_CTRL_STATS_EN defined, 3 frames plus 5 stalled cycles -> frame_cnt=3, stall_cnt=5; without the macro both read 0.
